// File: rtl/vid_pkg.sv
// Shared types and constants for the pixel shifter: state enum, default palette, pixels-per-word.
package vid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STARVE = 2'd2
    } vid_state_t;

    localparam logic [2:0] RGB_BLACK = 3'b000;
    localparam logic [2:0] RGB_WHITE = 3'b111;
    localparam logic [2:0] PAL_RST_0 = 3'b000;
    localparam logic [2:0] PAL_RST_1 = 3'b001;
    localparam logic [2:0] PAL_RST_2 = 3'b010;
    localparam logic [2:0] PAL_RST_3 = 3'b100;

    // Colour packs two bits per pixel, mono one.
    function automatic int unsigned pix_per_word(input int unsigned dw, input logic mono);
        return mono ? dw : dw / 2;
    endfunction

endpackage

// File: rtl/vid_palette.sv
// Pixel code to RGB map. With VID_PALETTE_EN defined the map is a writable 4x3 palette,
// otherwise it is the fixed colour/mono map and the write port is ignored.
module vid_palette
    import vid_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pal_we,
    input  logic [1:0] pal_a,
    input  logic [2:0] pal_d,
    input  logic       mono,
    input  logic [1:0] code,
    output logic [2:0] rgb_c
);

`ifdef VID_PALETTE_EN
    logic [2:0] pal [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pal[0] <= PAL_RST_0;
            pal[1] <= PAL_RST_1;
            pal[2] <= PAL_RST_2;
            pal[3] <= PAL_RST_3;
        end else if (pal_we) begin
            pal[pal_a] <= pal_d;
        end
    end

    // Mono uses the two outer entries so a colour palette also drives mono sensibly.
    always_comb begin
        rgb_c = pal[code];
        if (mono) begin
            rgb_c = code[0] ? pal[3] : pal[0];
        end
    end
`else
    logic unused_pal;
    assign unused_pal = ^{clk, rst_n, pal_we, pal_a, pal_d};

    always_comb begin
        rgb_c = RGB_BLACK;
        if (mono) begin
            rgb_c = code[0] ? RGB_WHITE : RGB_BLACK;
        end else begin
            case (code)
                2'd1:    rgb_c = PAL_RST_1;
                2'd2:    rgb_c = PAL_RST_2;
                2'd3:    rgb_c = PAL_RST_3;
                default: rgb_c = PAL_RST_0;
            endcase
        end
    end
`endif

endmodule

// File: rtl/vid_pixel_shifter.sv
// Video pixel shifter: double-buffered RAM word into a shift register, one pixel per PCE.
// Optional writable palette enabled by macro VID_PALETTE_EN.
module vid_pixel_shifter
    import vid_pkg::*;
#(
    parameter int unsigned DW = 16
)
(
    input  logic          PIN_CLK,
    input  logic          PIN_nR,
    input  logic          PIN_PCE,
    input  logic          PIN_MODE,
    input  logic          PIN_WTI,
    input  logic [DW-1:0] PIN_D,
    input  logic          PIN_BLANK,
    input  logic          PIN_UNF_CLR,
    input  logic          PIN_PAL_WE,
    input  logic [1:0]    PIN_PAL_A,
    input  logic [2:0]    PIN_PAL_D,
    output logic          PIN_REQ,
    output logic [2:0]    PIN_RGB,
    output logic          PIN_UNF
);

    localparam int unsigned PCW = $clog2(DW + 1);

    vid_state_t     state;
    logic [DW-1:0]  hold;
    logic           hv;
    logic [DW-1:0]  sr;
    logic [PCW-1:0] pc;
    logic           mq;

    logic           boundary_c;
    logic           underrun_c;
    logic [1:0]     code_c;
    logic [2:0]     pal_rgb_c;

    assign PIN_REQ    = ~hv;
    assign boundary_c = PIN_PCE && ((state != ST_RUN) || (pc == PCW'(1)));
    assign underrun_c = boundary_c && !hv && !PIN_WTI && (state == ST_RUN);
    assign code_c     = mq ? {1'b0, sr[0]} : sr[1:0];

    // Word loading, pixel shifting and starvation tracking.
    always_ff @(posedge PIN_CLK or negedge PIN_nR) begin
        if (!PIN_nR) begin
            state <= ST_IDLE;
            hold  <= '0;
            hv    <= 1'b0;
            sr    <= '0;
            pc    <= '0;
            mq    <= 1'b0;
        end else if (boundary_c) begin
            if (hv || PIN_WTI) begin
                // Holding register has priority; with it empty a coincident strobe bypasses into SR.
                sr    <= hv ? hold : PIN_D;
                mq    <= PIN_MODE;
                pc    <= PCW'(pix_per_word(DW, PIN_MODE));
                state <= ST_RUN;
                if (hv) begin
                    if (PIN_WTI) begin
                        hold <= PIN_D;
                    end else begin
                        hv <= 1'b0;
                    end
                end
            end else if (state == ST_RUN) begin
                state <= ST_STARVE;
                pc    <= '0;
                sr    <= '0;
            end
        end else begin
            if (PIN_WTI) begin
                hold <= PIN_D;
                hv   <= 1'b1;
            end
            if (PIN_PCE && (state == ST_RUN)) begin
                sr <= mq ? (sr >> 1) : (sr >> 2);
                pc <= pc - PCW'(1);
            end
        end
    end

    // Sticky underrun; a new underrun wins over a clear in the same cycle.
    always_ff @(posedge PIN_CLK or negedge PIN_nR) begin
        if (!PIN_nR) begin
            PIN_UNF <= 1'b0;
        end else if (underrun_c) begin
            PIN_UNF <= 1'b1;
        end else if (PIN_UNF_CLR) begin
            PIN_UNF <= 1'b0;
        end
    end

    vid_palette u_palette (
        .clk    (PIN_CLK),
        .rst_n  (PIN_nR),
        .pal_we (PIN_PAL_WE),
        .pal_a  (PIN_PAL_A),
        .pal_d  (PIN_PAL_D),
        .mono   (mq),
        .code   (code_c),
        .rgb_c  (pal_rgb_c)
    );

    always_ff @(posedge PIN_CLK or negedge PIN_nR) begin
        if (!PIN_nR) begin
            PIN_RGB <= RGB_BLACK;
        end else if (PIN_BLANK || (state != ST_RUN)) begin
            PIN_RGB <= RGB_BLACK;
        end else begin
            PIN_RGB <= pal_rgb_c;
        end
    end

endmodule

// File: doc/vid_pixel_shifter.md
VID_PIXEL_SHIFTER -- requirements
Module: vid_pixel_shifter

Interface
REQ-001 Parameter DW, default 16, RAM word width in bits; SHALL be even and >= 4.
REQ-002 PIN_CLK  in  1  system clock; all state on rising edge.
REQ-003 PIN_nR  in  1  reset, asynchronous, active-low.
REQ-004 PIN_PCE  in  1  pixel clock enable; one pixel advance per PCE cycle.
REQ-005 PIN_MODE  in  1  0 = colour 2 bpp (DW/2 pixels/word), 1 = mono 1 bpp (DW pixels/word).
REQ-006 PIN_WTI  in  1  word-load strobe, one cycle, qualifies PIN_D.
REQ-007 PIN_D  in  DW  video word from RAM; bit 2k = even plane, bit 2k+1 = odd plane.
REQ-008 PIN_BLANK  in  1  forces black output.
REQ-009 PIN_UNF_CLR  in  1  clears sticky underrun flag.
REQ-010 PIN_PAL_WE / PIN_PAL_A / PIN_PAL_D  in  1/2/3  palette write port; always present.
REQ-011 PIN_REQ  out  1  holding register empty, next word wanted.
REQ-012 PIN_RGB  out  3  {R,G,B} pixel, registered.
REQ-013 PIN_UNF  out  1  sticky underrun flag.

Function
REQ-014 Storage: holding register HOLD with valid flag HV; shift register SR (DW); pixel counter PC; per-word latched mode MQ.
REQ-015 PIN_REQ SHALL equal ~HV combinationally from the HV flop.
REQ-016 WTI with HV=0 at a non-boundary cycle: HOLD<=PIN_D, HV<=1; WTI with HV=1: HOLD overwritten (latest wins), HV stays 1, no error.
REQ-017 States IDLE (never started), RUN, STARVE; boundary = PCE in IDLE/STARVE, or PCE in RUN with PC==1.
REQ-018 At boundary with HV=1: SR<=HOLD, MQ<=PIN_MODE, PC<=pixels/word, HV<=0 unless WTI same cycle (then HOLD<=PIN_D, HV=1); state RUN.
REQ-019 At boundary with HV=0 and WTI: bypass, SR<=PIN_D directly, HV stays 0, state RUN, no underrun.
REQ-020 At boundary with HV=0, no WTI: from RUN go STARVE, PC<=0, SR<=0, PIN_UNF<=1; IDLE/STARVE hold state, no new UNF set.
REQ-021 PCE in RUN with PC>1: colour SR shifts right 2, mono right 1; zeros fill; PC decrements.
REQ-022 Current pixel code: colour {SR[1],SR[0]}; mono SR[0].
REQ-023 Fixed map: colour 00->000, 01->001 blue, 10->010 green, 11->100 red; mono 0->000, 1->111.
REQ-024 PIN_RGB SHALL register the mapped code every clock, one-clock latency after SR change; 000 when PIN_BLANK=1 or state is IDLE/STARVE.
REQ-025 PIN_MODE changes SHALL take effect only at the next word load.
REQ-026 PIN_UNF set has priority over PIN_UNF_CLR in the same cycle.

Reset
REQ-027 On PIN_nR=0, immediately: HOLD=0, HV=0, SR=0, PC=0, MQ=0, state IDLE, PIN_RGB=000, PIN_REQ=1, PIN_UNF=0, palette = fixed-map values; mid-word reset discards all pixels.

Configuration
REQ-028 Macro VID_PALETTE_EN defined: 4x3-bit palette, written by PIN_PAL_WE at PIN_PAL_A with PIN_PAL_D; colour code n maps to pal[n], mono 0->pal[0], 1->pal[3]; reset values 000/001/010/100 in colour (mono uses pal[3]=100 after reset).
REQ-029 Macro undefined: palette ports ignored, fixed map of REQ-023 used.

Structure
REQ-030 Package vid_pkg SHALL hold the state enum, default palette constants and pixels-per-word function of DW and mode.
REQ-031 One sub-module vid_palette SHALL contain the palette registers and code-to-RGB map (fixed map when macro off).

Verification (DW=16)
REQ-032 Colour, WTI 16'hAAAA, then 16'h5555 while REQ=1 -> 8 pixels RGB=010, then 8 pixels RGB=001, UNF=0.
REQ-033 Single word 16'hFFFF, no further WTI -> 8 pixels 100, then RGB=000, state STARVE, UNF=1; UNF_CLR -> UNF=0.
REQ-034 Mono, WTI 16'h0001 -> first pixel 111, next 15 pixels 000; MODE toggled mid-word has no effect until next load.
REQ-035 WTI coincident with boundary while HV=0 -> bypass load, REQ stays 1, UNF stays 0, no black gap.
REQ-036 PIN_nR low at pixel 3 -> RGB=000, REQ=1, state IDLE within same cycle, no clock needed.
REQ-037 VID_PALETTE_EN on: write pal[2]=110, load 16'hAAAA -> RGB=110; macro off, same stimulus -> RGB=010.
